wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_if.sv | 31 +++
 rtl/wb_regfile.sv | 58 +++++
 tb/tb_wb_regfile.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Writeback / register-read bus of the wb_regfile block.
// master drives MEM/WB fields and read indices; slave returns read data and status.
interface wb_regfile_if;
    logic        wb_mem_to_reg;
    logic        wb_write_reg;
    logic        wb_pcs;
    logic        wb_halt;
    logic [3:0]  wb_dst_reg;
    logic [15:0] wb_alu_out;
    logic [15:0] wb_mem_data;
    logic [15:0] wb_pc_nxt;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic [15:0] wb_data;
    logic        hlt;
    logic [15:0] wr_count;

    modport master (
        output wb_mem_to_reg, wb_write_reg, wb_pcs, wb_halt, wb_dst_reg,
        output wb_alu_out, wb_mem_data, wb_pc_nxt, rd_reg1, rd_reg2,
        input  rd_data1, rd_data2, wb_data, hlt, wr_count
    );

    modport slave (
        input  wb_mem_to_reg, wb_write_reg, wb_pcs, wb_halt, wb_dst_reg,
        input  wb_alu_out, wb_mem_data, wb_pc_nxt, rd_reg1, rd_reg2,
        output rd_data1, rd_data2, wb_data, hlt, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// 16x16 register file with writeback mux, same-cycle write bypass,
// halt latch and saturating commit counter.
module wb_regfile (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    localparam int NUM_RD = 2;
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]  state;
    logic [15:0] regs [16];
    logic [15:0] wb_sel;
    logic [15:0] wr_cnt;
    logic        commit;

    logic [NUM_RD-1:0][3:0]  rd_idx;
    logic [NUM_RD-1:0][15:0] rd_val;

    always_comb begin
        wb_sel = bus.wb_alu_out;
        if (bus.wb_pcs)
            wb_sel = bus.wb_pc_nxt;
        else if (bus.wb_mem_to_reg)
            wb_sel = bus.wb_mem_data;
    end

    // dst 0 never commits, so regs[0] holds its reset value of zero forever
    assign commit = bus.wb_write_reg && (bus.wb_dst_reg != 4'd0) && (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            wr_cnt <= 16'h0000;
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
        end else begin
            if (commit) begin
                regs[bus.wb_dst_reg] <= wb_sel;
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end
            if (state == ST_RUN && bus.wb_halt) state <= ST_HALTED;
        end
    end

    assign rd_idx = {bus.rd_reg2, bus.rd_reg1};

    // commit already excludes HALTED, so no bypass happens once halted
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_val[p] = (commit && rd_idx[p] == bus.wb_dst_reg) ? wb_sel : regs[rd_idx[p]];
    end

    assign bus.rd_data1 = rd_val[0];
    assign bus.rd_data2 = rd_val[1];
    assign bus.wb_data  = wb_sel;
    assign bus.hlt      = (state == ST_HALTED);
    assign bus.wr_count = wr_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_regfile_if bus();

    wb_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_regs [16];
    logic        m_halted;
    int          m_cnt;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_sel();
        if (bus.wb_pcs) return bus.wb_pc_nxt;
        if (bus.wb_mem_to_reg) return bus.wb_mem_data;
        return bus.wb_alu_out;
    endfunction

    function automatic bit m_commit();
        return bus.wb_write_reg && bus.wb_dst_reg != 4'd0 && !m_halted;
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] idx);
        if (m_commit() && idx == bus.wb_dst_reg) return m_sel();
        return m_regs[idx];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_halted = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic drive(input bit wr, input bit mtr, input bit pcs, input bit halt,
                         input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] mem,
                         input logic [15:0] pc, input logic [3:0] r1, input logic [3:0] r2);
        bus.wb_write_reg  = wr;
        bus.wb_mem_to_reg = mtr;
        bus.wb_pcs        = pcs;
        bus.wb_halt       = halt;
        bus.wb_dst_reg    = dst;
        bus.wb_alu_out    = alu;
        bus.wb_mem_data   = mem;
        bus.wb_pc_nxt     = pc;
        bus.rd_reg1       = r1;
        bus.rd_reg2       = r2;
    endtask

    // One full cycle: drive at negedge, check combinational outputs, clock, check state.
    task automatic step(input bit wr, input bit mtr, input bit pcs, input bit halt,
                        input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] mem,
                        input logic [15:0] pc, input logic [3:0] r1, input logic [3:0] r2);
        @(negedge clk);
        drive(wr, mtr, pcs, halt, dst, alu, mem, pc, r1, r2);
        #1;
        chk("wb_data", bus.wb_data, m_sel());
        chk("rd_data1", bus.rd_data1, m_read(r1));
        chk("rd_data2", bus.rd_data2, m_read(r2));
        @(posedge clk);
        if (m_commit()) begin
            m_regs[dst] = m_sel();
            if (m_cnt < 65535) m_cnt++;
        end
        if (halt) m_halted = 1'b1;
        #1;
        chk("hlt", {15'd0, bus.hlt}, {15'd0, m_halted});
        chk("wr_count", bus.wr_count, m_cnt[15:0]);
    endtask

    task automatic rand_step(input bit force_wr);
        logic [3:0] dst;
        dst = force_wr ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
        step(force_wr || ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0,
             dst, 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? dst : 4'($urandom_range(0, 15)));
    endtask

    initial begin
        m_reset();
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);

        // Reset state
        #2;
        chk("rst_hlt", {15'd0, bus.hlt}, 16'h0000);
        chk("rst_wr_count", bus.wr_count, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            bus.rd_reg1 = 4'(i);
            bus.rd_reg2 = 4'(15 - i);
            #1;
            chk("rst_rd1", bus.rd_data1, 16'h0000);
            chk("rst_rd2", bus.rd_data2, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Write R3 with same-cycle bypass
        @(negedge clk);
        drive(1, 0, 0, 0, 4'd3, 16'h1234, 16'h0, 16'h0, 4'd3, 4'd3);
        #1;
        chk("r3_bypass1", bus.rd_data1, 16'h1234);
        chk("r3_bypass2", bus.rd_data2, 16'h1234);
        @(posedge clk);
        m_regs[3] = 16'h1234;
        m_cnt = 1;
        #1;
        chk("r3_count", bus.wr_count, 16'h0001);
        @(negedge clk);
        bus.wb_write_reg = 1'b0;
        #1;
        chk("r3_stored", bus.rd_data1, 16'h1234);

        // Mux priority into R5
        step(1, 1, 1, 0, 4'd5, 16'h1111, 16'hBEEF, 16'h0042, 4'd5, 4'd0);
        chk("r5_pcs_wins", m_regs[5], 16'h0042);
        step(1, 1, 0, 0, 4'd5, 16'h1111, 16'hBEEF, 16'h0042, 4'd5, 4'd5);
        step(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd5, 4'd3);
        chk("r5_stored", bus.rd_data1, 16'hBEEF);

        // R0 write discarded and not counted
        step(1, 0, 0, 0, 4'd0, 16'hFFFF, 16'h0, 16'h0, 4'd0, 4'd0);
        chk("r0_count", bus.wr_count, 16'h0003);
        step(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0);
        chk("r0_zero", bus.rd_data1, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) rand_step(1'b0);

        // Halt with simultaneous write, then suppressed write
        step(1, 0, 0, 0, 4'd2, 16'h0F0F, 16'h0, 16'h0, 4'd2, 4'd7);
        step(1, 0, 0, 1, 4'd7, 16'h00AA, 16'h0, 16'h0, 4'd7, 4'd2);
        chk("halt_hlt", {15'd0, bus.hlt}, 16'h0001);
        m_cnt = m_cnt;
        begin
            int cnt_at_halt;
            cnt_at_halt = m_cnt;
            step(1, 0, 0, 0, 4'd7, 16'h5555, 16'h0, 16'h0, 4'd7, 4'd2);
            chk("halt_no_bypass", m_regs[7], 16'h00AA);
            step(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd7, 4'd2);
            chk("halt_r7", bus.rd_data1, 16'h00AA);
            chk("halt_r2", bus.rd_data2, 16'h0F0F);
            chk("halt_count", bus.wr_count, 16'(cnt_at_halt));
        end
        for (int i = 0; i < 50; i++) rand_step(1'b0);

        // Async reset between edges
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd2, 4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hlt", {15'd0, bus.hlt}, 16'h0000);
        chk("arst_count", bus.wr_count, 16'h0000);
        chk("arst_r2", bus.rd_data1, 16'h0000);
        chk("arst_r7", bus.rd_data2, 16'h0000);
        m_reset();
        // A write presented while reset is held must be dropped
        drive(1, 0, 0, 0, 4'd2, 16'h7777, 16'h0, 16'h0, 4'd2, 4'd2);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_write_reg = 1'b0;
        #1;
        chk("arst_abort", bus.rd_data1, 16'h0000);
        step(1, 0, 0, 0, 4'd2, 16'h0F0F, 16'h0, 16'h0, 4'd2, 4'd2);
        step(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd2, 4'd0);
        chk("arst_r2_write", bus.rd_data1, 16'h0F0F);
        chk("arst_count1", bus.wr_count, 16'h0001);

        // Saturation
        for (int i = 0; i < 65536; i++) rand_step(1'b1);
        chk("sat_count", bus.wr_count, 16'hFFFF);
        for (int i = 0; i < 20; i++) rand_step(1'b1);
        chk("sat_hold", bus.wr_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, budget exhausted");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end
endmodule
